pwm_deadtime_gen: RTL and testbench
===================================

// Module: pwm_deadtime_gen
// PURPOSE
//   Converts the three single-ended PWM phase signals from the FOC top into complementary
//   high-side/low-side gate drive pairs, with a programmable dead time on every edge.
//   Sits directly downstream of the SPI/FOC wrapper's pwmA/pwmB/pwmC outputs.
//   Drives the inverter gate driver pins.
//   Guarantees no shoot-through: xh and xl are never both 1.
// PARAMETERS
//   DT_WIDTH   8   width of the dead-time count (cycles of clk_sys)
// PORTS
//   clk_sys      in   1          system clock
//   rstb         in   1          asynchronous reset, active-low
//   enable       in   1          1 = gate drive allowed; 0 = all gates off
//   dead_cycles  in   DT_WIDTH   dead time in clk_sys cycles; sampled on entry to a DEAD state
//   pwmA_in      in   1          phase A command, clk_sys domain
//   pwmB_in      in   1          phase B command, clk_sys domain
//   pwmC_in      in   1          phase C command, clk_sys domain
//   ah, al       out  1          phase A high-side / low-side gate, registered
//   bh, bl       out  1          phase B high-side / low-side gate, registered
//   ch, cl       out  1          phase C high-side / low-side gate, registered
//   busy         out  1          OR of all phases currently in a DEAD state
// BEHAVIOUR
// - Reset: all six gate outputs 0, busy 0, every phase FSM in OFF, all counters 0.
// - Phase FSMs: three identical, independent per-phase FSMs (one per input, one counter each).
//     States: OFF, LO, DEAD_LH, HI, DEAD_HL.
//     Gate encoding: OFF {h,l}=00; LO 01; HI 10; DEAD_* 00.
// - Outputs are a registered decode of the state; no combinational path from input to gate.
// - enable=0: every FSM goes to OFF on the next edge, from any state; counters cleared.
// - OFF & enable=1:
//     pwm=1 -> DEAD_LH; pwm=0 -> DEAD_HL.
//     Either way cnt <= dead_cycles, so a full dead time follows every enable.
// - LO & pwm=1 -> DEAD_LH, cnt <= dead_cycles.
// - HI & pwm=0 -> DEAD_HL, cnt <= dead_cycles.
// - DEAD_LH:
//     pwm=0 -> LO (abort; the high side never turned on).
//     else if cnt<=1 -> HI.
//     else cnt <= cnt-1.
// - DEAD_HL is symmetric: pwm=1 -> HI (abort); cnt<=1 -> LO; else decrement.
// - Both-off interval = max(dead_cycles,1) cycles; dead_cycles=0 behaves as 1.
// - Latency: pwm edge sampled at edge n.
//     Both gates are 0 from edge n (DEAD entered at n).
//     The new side turns on at edge n+max(dead_cycles,1).
// - A dead_cycles change mid-count has no effect until the next DEAD entry.
// - Glitch rejection: a pulse shorter than the dead time produces no gate activity on the new side.
// - Counter never underflows.
// - Shoot-through: the encoding makes h&l=1 unreachable; a formal assertion must hold in every state.
// - busy: registered alongside the gates; 1 while any phase is in DEAD_LH or DEAD_HL.
// CONFIGURATION
// - Macro PWM_FAULT_LATCH_EN. When defined, adds these ports:
//     fault_n      in   1   active-low fault input
//     fault_clr    in   1   fault clear request
//     fault_latch  out  1   latched fault flag
// - Fault set: fault_n=0 sampled at a clock edge sets fault_latch=1.
//     All FSMs go to OFF on the same edge, so gates are 0 one cycle after sampling.
//     The FSMs behave as if enable=0 while fault_latch=1.
// - fault_clr=1 with fault_n=1 clears fault_latch on the next edge.
//     If fault_clr=1 and fault_n=0 at the same edge, fault wins and the latch stays 1.
// - After clear, recovery follows the OFF exit path above (full dead time).
// - fault_latch resets to 0.
// - Without the macro: these ports do not exist and no fault logic is present.
// TESTING
// 1. Reset then enable=1, dead_cycles=4, pwmA=0 held.
//      -> al=0 for 4 cycles, then al=1; ah stays 0; busy=1 for exactly those 4 cycles.
// 2. Steady LO, then pwmA 0->1 at edge n, dead_cycles=5.
//      -> al=0 from n; ah=1 from n+5; {ah,al}=00 for n..n+4.
//      -> Repeat 1->0 with the mirrored result.
// 3. dead_cycles=6, pwmB pulse high for 3 cycles from LO.
//      -> bh never asserts; bl returns to 1 when pwmB falls; no 11 state seen.
// 4. dead_cycles=0, toggle pwmC every 2 cycles.
//      -> exactly 1 both-off cycle per edge; ch/cl alternate.
//      -> Then change dead_cycles to 3 mid-DEAD: the current interval is unaffected, the next is 3.
// 5. Reset and enable: assert rstb=0 mid-DEAD_LH -> all gates 0 immediately (async).
//      Drop enable mid-HI -> gates 00 next edge.
//      Re-enable -> full dead time before any gate rises.
// 6. [PWM_FAULT_LATCH_EN] Fault while phases are driving, dead_cycles=2.
//      - fault_n low 1 cycle -> all gates 0 next edge, fault_latch=1 persists.
//      - fault_clr with fault_n=0 -> latch held.
//      - fault_clr with fault_n=1 -> latch clears, gates resume after 2 dead cycles.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// Three-phase complementary gate driver with programmable dead time on every edge.
// Optional fault latch is compiled in when PWM_FAULT_LATCH_EN is defined.
module pwm_deadtime_gen #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_sys,
  input  logic                rstb,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  input  logic                pwmA_in,
  input  logic                pwmB_in,
  input  logic                pwmC_in,
`ifdef PWM_FAULT_LATCH_EN
  input  logic                fault_n,
  input  logic                fault_clr,
  output logic                fault_latch,
`endif
  output logic                ah,
  output logic                al,
  output logic                bh,
  output logic                bl,
  output logic                ch,
  output logic                cl,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_LO      = 3'd1,
    S_DEAD_LH = 3'd2,
    S_HI      = 3'd3,
    S_DEAD_HL = 3'd4
  } phase_state_t;

  localparam int                NPH     = 3;
  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  logic [NPH-1:0] pwm_vec;
  logic [NPH-1:0] h_vec;
  logic [NPH-1:0] l_vec;
  logic [NPH-1:0] dead_next_vec;
  logic           drive_en;
  logic           busy_reg;

  assign pwm_vec = {pwmC_in, pwmB_in, pwmA_in};

`ifdef PWM_FAULT_LATCH_EN
  logic fault_latch_reg;

  // A fault sampled this edge wins over a simultaneous clear request.
  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      fault_latch_reg <= 1'b0;
    end else if (!fault_n) begin
      fault_latch_reg <= 1'b1;
    end else if (fault_clr) begin
      fault_latch_reg <= 1'b0;
    end
  end

  assign drive_en    = enable && fault_n && !fault_latch_reg;
  assign fault_latch = fault_latch_reg;
`else
  assign drive_en = enable;
`endif

  for (genvar gi = 0; gi < NPH; gi++) begin : g_phase
    phase_state_t        state_reg, state_next;
    logic [DT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                h_reg, l_reg;

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (!drive_en) begin
        state_next = S_OFF;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          S_OFF: begin
            state_next = pwm_vec[gi] ? S_DEAD_LH : S_DEAD_HL;
            cnt_next   = dead_cycles;
          end
          S_LO: begin
            if (pwm_vec[gi]) begin
              state_next = S_DEAD_LH;
              cnt_next   = dead_cycles;
            end
          end
          S_HI: begin
            if (!pwm_vec[gi]) begin
              state_next = S_DEAD_HL;
              cnt_next   = dead_cycles;
            end
          end
          S_DEAD_LH: begin
            if (!pwm_vec[gi]) begin
              state_next = S_LO;
              cnt_next   = '0;
            end else if (cnt_reg <= CNT_ONE) begin
              state_next = S_HI;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          S_DEAD_HL: begin
            if (pwm_vec[gi]) begin
              state_next = S_HI;
              cnt_next   = '0;
            end else if (cnt_reg <= CNT_ONE) begin
              state_next = S_LO;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          default: begin
            state_next = S_OFF;
            cnt_next   = '0;
          end
        endcase
      end
    end

    // Gates are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_sys or negedge rstb) begin
      if (!rstb) begin
        state_reg <= S_OFF;
        cnt_reg   <= '0;
        h_reg     <= 1'b0;
        l_reg     <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        h_reg     <= (state_next == S_HI);
        l_reg     <= (state_next == S_LO);
      end
    end

    assign h_vec[gi]         = h_reg;
    assign l_vec[gi]         = l_reg;
    assign dead_next_vec[gi] = (state_next == S_DEAD_LH) || (state_next == S_DEAD_HL);

    a_no_shoot_through: assert property (@(posedge clk_sys) disable iff (!rstb) !(h_reg && l_reg));
  end

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= |dead_next_vec;
    end
  end

  assign ah   = h_vec[0];
  assign al   = l_vec[0];
  assign bh   = h_vec[1];
  assign bl   = l_vec[1];
  assign ch   = h_vec[2];
  assign cl   = l_vec[2];
  assign busy = busy_reg;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: per-cycle comparison against a side/timer model
// plus hand-computed spot checks.
module tb_pwm_deadtime_gen;

  logic       clk_sys = 1'b0;
  logic       rstb = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] dead_cycles = 8'd0;
  logic       pwmA_in = 1'b0;
  logic       pwmB_in = 1'b0;
  logic       pwmC_in = 1'b0;
  logic       ah, al, bh, bl, ch, cl, busy;
`ifdef PWM_FAULT_LATCH_EN
  logic       fault_n = 1'b1;
  logic       fault_clr = 1'b0;
  logic       fault_latch;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk_sys = ~clk_sys;

  pwm_deadtime_gen #(.DT_WIDTH(8)) dut (
    .clk_sys     (clk_sys),
    .rstb        (rstb),
    .enable      (enable),
    .dead_cycles (dead_cycles),
    .pwmA_in     (pwmA_in),
    .pwmB_in     (pwmB_in),
    .pwmC_in     (pwmC_in),
`ifdef PWM_FAULT_LATCH_EN
    .fault_n     (fault_n),
    .fault_clr   (fault_clr),
    .fault_latch (fault_latch),
`endif
    .ah          (ah),
    .al          (al),
    .bh          (bh),
    .bl          (bl),
    .ch          (ch),
    .cl          (cl),
    .busy        (busy)
  );

  // Model per phase: which side is on (0 none, 1 low, 2 high), whether a both-off
  // interval is running, the side it leads to, and the cycles left in it.
  int   m_on [3];
  bit   m_dead [3];
  bit   m_tgt [3];
  int   m_rem [3];
  bit   m_latch;
  bit   m_en;
  logic [2:0] pwm_v;

  assign pwm_v = {pwmC_in, pwmB_in, pwmA_in};

  always @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      for (int p = 0; p < 3; p++) begin
        m_on[p]   = 0;
        m_dead[p] = 1'b0;
        m_tgt[p]  = 1'b0;
        m_rem[p]  = 0;
      end
      m_latch = 1'b0;
    end else begin
      m_en = enable;
`ifdef PWM_FAULT_LATCH_EN
      m_en = enable && fault_n && !m_latch;
      if (!fault_n) m_latch = 1'b1;
      else if (fault_clr) m_latch = 1'b0;
`endif
      for (int p = 0; p < 3; p++) begin
        if (!m_en) begin
          m_on[p]   = 0;
          m_dead[p] = 1'b0;
        end else if (m_dead[p]) begin
          if (pwm_v[p] != m_tgt[p]) begin
            m_on[p]   = pwm_v[p] ? 2 : 1;
            m_dead[p] = 1'b0;
          end else if (m_rem[p] <= 1) begin
            m_on[p]   = m_tgt[p] ? 2 : 1;
            m_dead[p] = 1'b0;
          end else begin
            m_rem[p] = m_rem[p] - 1;
          end
        end else if (m_on[p] != (pwm_v[p] ? 2 : 1)) begin
          m_dead[p] = 1'b1;
          m_tgt[p]  = pwm_v[p];
          m_rem[p]  = int'(dead_cycles);
          m_on[p]   = 0;
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    logic [6:0] exp_v;
    logic [6:0] act_v;
    exp_v = {m_on[0] == 2, m_on[0] == 1, m_on[1] == 2, m_on[1] == 1,
             m_on[2] == 2, m_on[2] == 1, m_dead[0] | m_dead[1] | m_dead[2]};
    act_v = {ah, al, bh, bl, ch, cl, busy};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL cycle t=%0t {ah,al,bh,bl,ch,cl,busy} got %b want %b", $time, act_v, exp_v);
    end
`ifdef PWM_FAULT_LATCH_EN
    total++;
    if (fault_latch !== m_latch) begin
      bad++;
      $display("FAIL cycle_latch t=%0t got %b want %b", $time, fault_latch, m_latch);
    end
`endif
  end

  task automatic chk(input string name, input logic act, input logic exp_val);
    total++;
    if (act !== exp_val) begin
      bad++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp_val);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  initial begin
    // 1. reset, then enable with pwm low: 4 both-off cycles before al
    dead_cycles = 8'd4;
    repeat (2) step();
    chk("rst_al", al, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rstb   = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t1_ah", ah, 1'b0);
      chk("t1_al", al, (i == 5));
      chk("t1_busy", busy, (i < 5));
    end
    $display("t1 enable-from-off done");

    // 2. LO -> HI with dead 5, then mirrored
    dead_cycles = 8'd5;
    pwmA_in = 1'b1;
    step();
    chk("t2_lh_n_al", al, 1'b0);
    chk("t2_lh_n_ah", ah, 1'b0);
    repeat (4) step();
    chk("t2_lh_n4_ah", ah, 1'b0);
    step();
    chk("t2_lh_n5_ah", ah, 1'b1);
    chk("t2_lh_n5_al", al, 1'b0);
    pwmA_in = 1'b0;
    step();
    chk("t2_hl_n_ah", ah, 1'b0);
    repeat (4) step();
    chk("t2_hl_n4_al", al, 1'b0);
    step();
    chk("t2_hl_n5_al", al, 1'b1);
    $display("t2 edge latency done");

    // 3. glitch shorter than dead time on phase B
    dead_cycles = 8'd6;
    pwmB_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_bh", bh, 1'b0);
      chk("t3_bl", bl, 1'b0);
    end
    pwmB_in = 1'b0;
    step();
    chk("t3_bl_back", bl, 1'b1);
    chk("t3_bh_back", bh, 1'b0);
    $display("t3 glitch rejection done");

    // 4. dead 0 behaves as one both-off cycle; mid-interval dead change
    dead_cycles = 8'd0;
    for (int k = 0; k < 4; k++) begin
      pwmC_in = ~pwmC_in;
      step();
      chk("t4_dead_ch", ch, 1'b0);
      chk("t4_dead_cl", cl, 1'b0);
      step();
      chk("t4_on_ch", ch, pwmC_in);
      chk("t4_on_cl", cl, ~pwmC_in);
    end
    pwmC_in = 1'b1;
    step();
    dead_cycles = 8'd3;
    step();
    chk("t4_chg_ch", ch, 1'b1);
    pwmC_in = 1'b0;
    step();
    repeat (2) step();
    chk("t4_n2_cl", cl, 1'b0);
    step();
    chk("t4_n3_cl", cl, 1'b1);
    $display("t4 zero dead and mid-count change done");

    // 5. async reset mid-dead, enable drop and re-enable
    pwmA_in = 1'b1;
    step();
    chk("t5_pre_busy", busy, 1'b1);
    #2 rstb = 1'b0;
    #1;
    chk("t5_rst_bl", bl, 1'b0);
    chk("t5_rst_cl", cl, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    @(negedge clk_sys);
    rstb = 1'b1;
    step();
    chk("t5_rel_busy", busy, 1'b1);
    repeat (2) step();
    chk("t5_rel_n2_ah", ah, 1'b0);
    step();
    chk("t5_rel_n3_ah", ah, 1'b1);
    chk("t5_rel_n3_bl", bl, 1'b1);
    enable = 1'b0;
    step();
    chk("t5_dis_ah", ah, 1'b0);
    chk("t5_dis_bl", bl, 1'b0);
    chk("t5_dis_busy", busy, 1'b0);
    enable = 1'b1;
    step();
    chk("t5_en_busy", busy, 1'b1);
    repeat (2) step();
    chk("t5_en_n2_ah", ah, 1'b0);
    step();
    chk("t5_en_n3_ah", ah, 1'b1);
    $display("t5 reset and enable done");

`ifdef PWM_FAULT_LATCH_EN
    // 6. fault latch set, held against clear, then released
    dead_cycles = 8'd2;
    fault_n = 1'b0;
    step();
    fault_n = 1'b1;
    chk("t6_f_ah", ah, 1'b0);
    chk("t6_f_bl", bl, 1'b0);
    chk("t6_f_latch", fault_latch, 1'b1);
    repeat (2) step();
    chk("t6_hold_latch", fault_latch, 1'b1);
    chk("t6_hold_ah", ah, 1'b0);
    fault_clr = 1'b1;
    fault_n   = 1'b0;
    step();
    chk("t6_clr_lost", fault_latch, 1'b1);
    fault_n = 1'b1;
    step();
    chk("t6_clr_latch", fault_latch, 1'b0);
    chk("t6_clr_ah", ah, 1'b0);
    fault_clr = 1'b0;
    step();
    chk("t6_rec_busy", busy, 1'b1);
    step();
    chk("t6_rec_n1_ah", ah, 1'b0);
    step();
    chk("t6_rec_n2_ah", ah, 1'b1);
    chk("t6_rec_n2_bl", bl, 1'b1);
    $display("t6 fault latch done");
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
